// File: rtl/vcmd_parser.sv
// SPI video command parser: decodes opcode/argument bytes from the SPI domain
// and issues address/data write requests to the frame-memory controller.
module vcmd_parser #(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8
) (
  input  logic              MemClk,
  input  logic              Rst,
  input  logic              ByteRdy,
  input  logic [DWIDTH-1:0] ByteIn,
  input  logic              CSel,
  output logic              WrReq,
  output logic [AWIDTH-1:0] WrAddr,
  output logic [DWIDTH-1:0] WrData,
  input  logic              WrAck,
  output logic              Busy,
  output logic              ErrFlag
);

  typedef enum logic [2:0] {
    IDLE, ADDR0, ADDR1, ADDR2, COUNT, DATA, FILLVAL, FILL
  } state_t;

  state_t              state, stateNxt;
  logic                byteRdy_p0, byteRdy_p1, byteRdy_p2;
  logic                cSel_p0, cSel_p1;
  logic [AWIDTH-1:0]   addrPtr, addrPtrNxt, addrNext;
  logic [8:0]          count, countNxt;
  logic                holdValid, holdValidNxt;
  logic [DWIDTH-1:0]   holdData, holdDataNxt;
  logic [2*DWIDTH-1:0] shadow, shadowNxt;
  logic                isFill, isFillNxt;
  logic                wrReqNxt, busyNxt, errSet, errClr;
  logic [AWIDTH-1:0]   wrAddrNxt;
  logic [DWIDTH-1:0]   wrDataNxt;
  logic                accept, abort, hs, freeOut;

  assign accept   = byteRdy_p1 & ~byteRdy_p2;
  assign abort    = cSel_p1 & (state != IDLE);
  assign hs       = WrReq & WrAck;
  assign freeOut  = ~WrReq | hs;
  assign addrNext = hs ? addrPtr + AWIDTH'(1) : addrPtr;

  always_comb begin
    stateNxt     = state;
    wrReqNxt     = WrReq & ~hs;
    wrAddrNxt    = WrAddr;
    wrDataNxt    = WrData;
    addrPtrNxt   = addrNext;
    countNxt     = count;
    holdValidNxt = holdValid;
    holdDataNxt  = holdData;
    shadowNxt    = shadow;
    isFillNxt    = isFill;
    errSet       = 1'b0;
    errClr       = 1'b0;
    if (abort) begin
      // A write already on the bus still finishes; everything queued behind it is dropped.
      stateNxt     = IDLE;
      countNxt     = '0;
      holdValidNxt = 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          case (ByteIn)
            DWIDTH'(0): ;
            DWIDTH'(1): stateNxt = ADDR0;
            DWIDTH'(2): begin stateNxt = COUNT; isFillNxt = 1'b0; end
            DWIDTH'(3): begin stateNxt = COUNT; isFillNxt = 1'b1; end
            DWIDTH'(4): errClr = 1'b1;
            default:    errSet = 1'b1;
          endcase
        end
        ADDR0: if (accept) begin
          shadowNxt[2*DWIDTH-1:DWIDTH] = ByteIn;
          stateNxt = ADDR1;
        end
        ADDR1: if (accept) begin
          shadowNxt[DWIDTH-1:0] = ByteIn;
          stateNxt = ADDR2;
        end
        ADDR2: if (accept) begin
          addrPtrNxt = AWIDTH'({shadow, ByteIn});
          stateNxt   = IDLE;
        end
        COUNT: if (accept) begin
          countNxt = (ByteIn == '0) ? 9'd256 : 9'(ByteIn);
          stateNxt = isFill ? FILLVAL : DATA;
        end
        DATA: begin
          if (freeOut && holdValid) begin
            wrReqNxt     = 1'b1;
            wrAddrNxt    = addrNext;
            wrDataNxt    = holdData;
            holdValidNxt = 1'b0;
          end
          if (accept) begin
            if (count == '0) begin
              errSet = 1'b1;
            end else begin
              countNxt = count - 9'd1;
              if (freeOut && !holdValid) begin
                wrReqNxt  = 1'b1;
                wrAddrNxt = addrNext;
                wrDataNxt = ByteIn;
              end else if (freeOut || !holdValid) begin
                holdValidNxt = 1'b1;
                holdDataNxt  = ByteIn;
              end else begin
                errSet = 1'b1;
              end
            end
          end
          if (count == '0 && !holdValidNxt && !wrReqNxt) stateNxt = IDLE;
        end
        FILLVAL: if (accept) begin
          wrReqNxt  = 1'b1;
          wrAddrNxt = addrNext;
          wrDataNxt = ByteIn;
          stateNxt  = FILL;
        end
        FILL: begin
          if (accept) errSet = 1'b1;
          if (hs) begin
            countNxt = count - 9'd1;
            if (count == 9'd1) begin
              stateNxt = IDLE;
            end else begin
              wrReqNxt  = 1'b1;
              wrAddrNxt = addrNext;
            end
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
    busyNxt = (stateNxt != IDLE) || wrReqNxt;
  end

  always_ff @(posedge MemClk) begin
    if (Rst) begin
      byteRdy_p0 <= 1'b0;
      byteRdy_p1 <= 1'b0;
      byteRdy_p2 <= 1'b0;
      cSel_p0    <= 1'b0;
      cSel_p1    <= 1'b0;
      state      <= IDLE;
      WrReq      <= 1'b0;
      WrAddr     <= '0;
      WrData     <= '0;
      addrPtr    <= '0;
      count      <= '0;
      holdValid  <= 1'b0;
      isFill     <= 1'b0;
      ErrFlag    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      // stage boundary: SPI-domain strobes into MemClk, plus edge-detect delay
      byteRdy_p0 <= ByteRdy;
      byteRdy_p1 <= byteRdy_p0;
      byteRdy_p2 <= byteRdy_p1;
      cSel_p0    <= CSel;
      cSel_p1    <= cSel_p0;
      state      <= stateNxt;
      WrReq      <= wrReqNxt;
      WrAddr     <= wrAddrNxt;
      WrData     <= wrDataNxt;
      addrPtr    <= addrPtrNxt;
      count      <= countNxt;
      holdValid  <= holdValidNxt;
      isFill     <= isFillNxt;
      ErrFlag    <= errSet | (ErrFlag & ~errClr);
      Busy       <= busyNxt;
    end
    holdData <= holdDataNxt;
    shadow   <= shadowNxt;
  end

endmodule
